// File: rtl/mem_stream_reader.sv
// Purpose : reads a contiguous range of 32-bit memory words and emits each one as four bytes, most significant byte first.
// Latency : the first byte is valid two cycles after start is accepted; each word costs one fetch cycle plus four stream cycles.
// Backpr. : out_data/out_valid hold while out_ready is low; no fetch takes place until the current word has fully drained.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   start, base_addr,          command; sampled only while idle
//   word_count
//   mem_address, mem_wr,       memory initiator side (read-only: write lanes tied to 0)
//   mem_wrData0..3,
//   mem_rdData0..3             combinational read data, lane 0 = bits [31:24]
//   out_data, out_valid,       byte stream
//   out_ready
//   busy, done                 status: busy outside IDLE, done pulses once per command
module mem_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wrData0,
    output logic [DATA_W-1:0] mem_wrData1,
    output logic [DATA_W-1:0] mem_wrData2,
    output logic [DATA_W-1:0] mem_wrData3,
    input  logic [DATA_W-1:0] mem_rdData0,
    input  logic [DATA_W-1:0] mem_rdData1,
    input  logic [DATA_W-1:0] mem_rdData2,
    input  logic [DATA_W-1:0] mem_rdData3,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                      state_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [ADDR_W-1:0]           rem_q;
    // word_q[0] is lane 0 (the most significant byte), so idx_q walks MSB first.
    logic [3:0][DATA_W-1:0]      word_q;
    logic [1:0]                  idx_q;
    logic [DATA_W-1:0]           out_data_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        done_q;

    // The address register drives memory at all times; only the FETCH cycle
    // actually consumes the read data.
    assign mem_address = addr_q;
    assign mem_wr      = 1'b0;
    assign mem_wrData0 = '0;
    assign mem_wrData1 = '0;
    assign mem_wrData2 = '0;
    assign mem_wrData3 = '0;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= word_count;
                        busy_q <= 1'b1;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    word_q      <= {mem_rdData3, mem_rdData2, mem_rdData1, mem_rdData0};
                    idx_q       <= 2'd0;
                    out_data_q  <= mem_rdData0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_STREAM;
                end

                S_STREAM: begin
                    if (out_ready) begin
                        if (idx_q != 2'd3) begin
                            idx_q      <= idx_q + 2'd1;
                            out_data_q <= word_q[idx_q + 2'd1];
                        end else begin
                            out_valid_q <= 1'b0;
                            rem_q       <= rem_q - 1'b1;
                            if (rem_q == ADDR_W'(1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                // Wraps modulo 2^ADDR_W by plain overflow.
                                addr_q  <= addr_q + 1'b1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] word_count;
    logic [7:0] mem_address;
    logic       mem_wr;
    logic [7:0] mem_wrData0, mem_wrData1, mem_wrData2, mem_wrData3;
    logic [7:0] mem_rdData0, mem_rdData1, mem_rdData2, mem_rdData3;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;

    logic [31:0] mem_m [0:255];

    mem_stream_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_address(mem_address),
        .mem_wr     (mem_wr),
        .mem_wrData0(mem_wrData0),
        .mem_wrData1(mem_wrData1),
        .mem_wrData2(mem_wrData2),
        .mem_wrData3(mem_wrData3),
        .mem_rdData0(mem_rdData0),
        .mem_rdData1(mem_rdData1),
        .mem_rdData2(mem_rdData2),
        .mem_rdData3(mem_rdData3),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Combinational-read memory model.
    assign mem_rdData0 = mem_m[mem_address][31:24];
    assign mem_rdData1 = mem_m[mem_address][23:16];
    assign mem_rdData2 = mem_m[mem_address][15:8];
    assign mem_rdData3 = mem_m[mem_address][7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr !== 1'b0 || {mem_wrData0, mem_wrData1, mem_wrData2, mem_wrData3} !== 32'h0)
            wr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it cycle by cycle until done.
    // cyc = k means cycle T+k where T is the edge that accepted start.
    // stall_at/stall_len: out_ready low for cycles [stall_at, stall_at+stall_len).
    // pulse_at: cycle in which a stray start is driven (0 = none).
    task automatic run_cmd(input logic [7:0] base, input logic [7:0] cnt,
                           input int stall_at, input int stall_len,
                           input int exp_done, input int pulse_at, input string name);
        int          cyc;
        int          nbytes;
        bit          got_done;
        logic        prev_vld, prev_rdy;
        logic [7:0]  prev_dat;
        logic [7:0]  w_addr;
        logic [31:0] w;
        logic [7:0]  exp_b;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        out_ready  = 1'b1;
        tick();
        start      = 1'b0;
        base_addr  = 8'h77;
        word_count = 8'h09;
        cyc      = 1;
        nbytes   = 0;
        got_done = 1'b0;
        prev_vld = 1'b0;
        prev_rdy = 1'b1;
        prev_dat = 8'h00;
        while (cyc <= 300 && !got_done) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (pulse_at != 0 && cyc == pulse_at) begin
                start = 1'b1; base_addr = 8'h40; word_count = 8'h05;
            end else begin
                start = 1'b0; base_addr = 8'h77; word_count = 8'h09;
            end
            if (prev_vld && !prev_rdy) begin
                chk({name, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
                chk({name, "_hold_dat"}, {24'b0, out_data}, {24'b0, prev_dat});
            end
            if (stall_len == 0) begin
                chk({name, "_vld_pat"}, {31'b0, out_valid},
                    {31'b0, (cyc < exp_done) && (cyc % 5 != 1)});
                if (cyc % 5 == 1 && cyc < exp_done)
                    chk({name, "_fetch_addr"}, {24'b0, mem_address},
                        {24'b0, base + 8'(cyc / 5)});
            end
            chk({name, "_busy"}, {31'b0, busy}, 32'd1);
            if (out_valid && out_ready) begin
                w_addr = base + 8'(nbytes / 4);
                w      = mem_m[w_addr];
                exp_b  = w[31 - 8*(nbytes % 4) -: 8];
                chk({name, "_byte"}, {24'b0, out_data}, {24'b0, exp_b});
                nbytes++;
            end
            if (done) begin
                got_done = 1'b1;
                chk({name, "_done_cyc"}, cyc, exp_done);
                chk({name, "_done_novld"}, {31'b0, out_valid}, 32'd0);
            end else begin
                prev_vld = out_valid;
                prev_rdy = out_ready;
                prev_dat = out_data;
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        chk({name, "_timeout"}, {31'b0, got_done}, 32'd1);
        chk({name, "_nbytes"}, nbytes, 4 * int'(cnt));
        out_ready = 1'b1;
        tick();
        chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_idle_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem_m[i] = (32'(i) * 32'h01010101) ^ 32'h5A3C_96E1;
        mem_m[8'h10] = 32'hA1B2C3D4;
        mem_m[8'h00] = 32'h00010203;
        mem_m[8'h01] = 32'h04050607;
        mem_m[8'h02] = 32'h08090A0B;
        mem_m[8'hFF] = 32'hDEADBEEF;
        mem_m[8'h20] = 32'h5A6B7C8D;

        rst = 1'b1; start = 1'b0; base_addr = 8'h00; word_count = 8'h00; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data",  {24'b0, out_data}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_addr",  {24'b0, mem_address}, 32'd0);
        chk("rst_wr",    {31'b0, mem_wr}, 32'd0);

        // Reset together with start: reset wins.
        start = 1'b1; base_addr = 8'h10; word_count = 8'h01;
        tick();
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        chk("rst_start_addr", {24'b0, mem_address}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Single word, full throughput.
        run_cmd(8'h10, 8'd1, 0, 0, 6, 0, "single");
        // Three words: one fetch gap per word, done at T+16.
        run_cmd(8'h00, 8'd3, 0, 0, 16, 0, "multi");
        // Backpressure while 0xB2 (cycle T+3) is presented for 3 extra cycles.
        run_cmd(8'h10, 8'd1, 3, 3, 9, 0, "bp");
        // Zero count: done the cycle after start.
        run_cmd(8'h10, 8'd0, 0, 0, 1, 0, "zero");
        // Stray start during streaming of a 2-word command is ignored.
        run_cmd(8'h00, 8'd2, 0, 0, 11, 3, "ignore");
        // Address wrap 0xFF -> 0x00.
        run_cmd(8'hFF, 8'd2, 0, 0, 11, 0, "wrap");

        // Reset after the second byte of a 3-word command.
        start = 1'b1; base_addr = 8'h00; word_count = 8'd3; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_b0", {24'b0, out_data}, 32'h00);
        tick();
        chk("mid_b1", {24'b0, out_data}, 32'h01);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy}, 32'd0);
        chk("mid_rst_done",  {31'b0, done}, 32'd0);
        chk("mid_rst_data",  {24'b0, out_data}, 32'd0);
        chk("mid_rst_addr",  {24'b0, mem_address}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_quiet", {29'b0, done, busy, out_valid}, 32'd0);
        end
        run_cmd(8'h20, 8'd1, 0, 0, 6, 0, "after_rst");

        chk("mem_wr_never", wr_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
